// File: rtl/mac_feeder_pkg.sv
// Shared operand types and the feeder FSM state encoding.
package mac_feeder_pkg;

  localparam int unsigned NUM_W = 32;

  typedef logic [NUM_W-1:0] NUMBER;

  // One operand beat on the stream towards the MAC.
  typedef struct packed {
    logic  valid;
    NUMBER value;
  } Scalar;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    SETTLE = 3'd3,
    DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/mac_feeder.sv
// Operand buffer and sequencer that streams a dot product through an external
// MAC, then captures the accumulator and holds it for a ready/valid consumer.
module mac_feeder
  import mac_feeder_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  NUMBER         load_data,
  input  NUMBER         load_weight,
  input  logic          start,
  input  logic [AW:0]   len,
  output logic          busy,
  output Scalar         data_out,
  output Scalar         weight_out,
  output logic          mac_clear,
  input  NUMBER         mac_out,
  output NUMBER         result,
  output logic          result_valid,
  input  logic          result_ready
);

  localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_N   = (AW+1)'(1);

  state_e      state_q, state_d;
  logic [AW:0] n_q, n_d;
  logic [AW:0] cnt_q, cnt_d;
  Scalar       data_d, weight_d;
  NUMBER       result_d;
  logic        mac_clear_d, result_valid_d, busy_d;
  logic [AW-1:0] rd_addr_c;

  NUMBER dbuf [DEPTH];
  NUMBER wbuf [DEPTH];

  // Buffers are written only while idle and survive reset.
  always_ff @(posedge clk) begin
    if (load_en && (state_q == IDLE)) begin
      dbuf[load_addr] <= load_data;
      wbuf[load_addr] <= load_weight;
    end
  end

  // cnt_q is zeroed on start, so it addresses element 0 while in CLEAR.
  assign rd_addr_c = cnt_q[AW-1:0];

  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    cnt_d          = cnt_q;
    data_d         = '0;
    weight_d       = '0;
    mac_clear_d    = 1'b0;
    result_d       = result;
    result_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = CLEAR;
          n_d         = (len > DEPTH_N) ? DEPTH_N : len;
          cnt_d       = '0;
          mac_clear_d = 1'b1;
        end
      end
      CLEAR: begin
        if (n_q != '0) begin
          state_d  = STREAM;
          data_d   = '{valid: 1'b1, value: dbuf[rd_addr_c]};
          weight_d = '{valid: 1'b1, value: wbuf[rd_addr_c]};
          cnt_d    = ONE_N;
        end else begin
          state_d = SETTLE;
        end
      end
      STREAM: begin
        if (cnt_q == n_q) begin
          state_d = SETTLE;
        end else begin
          data_d   = '{valid: 1'b1, value: dbuf[rd_addr_c]};
          weight_d = '{valid: 1'b1, value: wbuf[rd_addr_c]};
          cnt_d    = cnt_q + ONE_N;
        end
      end
      SETTLE: begin
        state_d        = DONE;
        result_d       = mac_out;
        result_valid_d = 1'b1;
      end
      DONE: begin
        if (result_ready) begin
          state_d = IDLE;
        end else begin
          result_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      n_q          <= '0;
      cnt_q        <= '0;
      data_out     <= '0;
      weight_out   <= '0;
      mac_clear    <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      cnt_q        <= cnt_d;
      data_out     <= data_d;
      weight_out   <= weight_d;
      mac_clear    <= mac_clear_d;
      result       <= result_d;
      result_valid <= result_valid_d;
      busy         <= busy_d;
    end
  end

endmodule

// File: tb/tb_mac_feeder.sv
// Bench for mac_feeder paired with a behavioural floating-point MAC.
module tb_mac_feeder;
  import mac_feeder_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk;
  logic          rst;
  logic          load_en;
  logic [AW-1:0] load_addr;
  NUMBER         load_data;
  NUMBER         load_weight;
  logic          start;
  logic [AW:0]   len;
  logic          busy;
  Scalar         data_out;
  Scalar         weight_out;
  logic          mac_clear;
  NUMBER         mac_out;
  NUMBER         result;
  logic          result_valid;
  logic          result_ready;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] ref_d [DEPTH];
  logic [31:0] ref_w [DEPTH];

  typedef struct {
    int len;
    int hold;
    int exp_beats;
    int exp_lat;
  } vec_t;

  vec_t vecs [6];

  mac_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .load_weight(load_weight), .start(start), .len(len),
    .busy(busy), .data_out(data_out), .weight_out(weight_out), .mac_clear(mac_clear),
    .mac_out(mac_out), .result(result), .result_valid(result_valid),
    .result_ready(result_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-precision <-> real conversions for normal numbers and zero.
  function automatic real f2r(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:0] == 31'd0) return 0.0;
    e = 11'(int'(f[30:23]) + 896);
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] b;
    b = $realtobits(r);
    if (b[62:0] == 63'd0) return 32'd0;
    return {b[63], 8'(int'(b[62:52]) - 896), b[51:29]};
  endfunction

  function automatic logic [31:0] model_dot(input int n);
    real acc;
    acc = 0.0;
    for (int k = 0; k < n; k++) acc = acc + f2r(ref_d[k]) * f2r(ref_w[k]);
    return r2f(acc);
  endfunction

  function automatic logic [31:0] rnd_num();
    return r2f(real'($urandom_range(0, 15)));
  endfunction

  // Behavioural MAC: clear on mac_clear, accumulate on every valid beat pair.
  always @(posedge clk) begin
    if (rst || mac_clear) mac_out <= 32'd0;
    else if (data_out.valid && weight_out.valid)
      mac_out <= r2f(f2r(mac_out) + f2r(data_out.value) * f2r(weight_out.value));
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int addr, input logic [31:0] d, input logic [31:0] w);
    load_en = 1'b1; load_addr = AW'(addr); load_data = d; load_weight = w;
    tick();
    load_en = 1'b0;
    ref_d[addr] = d; ref_w[addr] = w;
  endtask

  // One full transaction; inj >= 0 drives a junk load on that cycle after start.
  task automatic run(input int ln, input int hold, input bit pulse, input int inj,
                     input bit cl, input int cl_addr, input logic [31:0] cl_d,
                     input logic [31:0] cl_w, output logic [31:0] got);
    int n, beats, clears, lat;
    logic [31:0] exp_res;
    n = (ln > DEPTH) ? DEPTH : ln;
    if (cl) begin
      load_en = 1'b1; load_addr = AW'(cl_addr); load_data = cl_d; load_weight = cl_w;
      ref_d[cl_addr] = cl_d; ref_w[cl_addr] = cl_w;
    end
    exp_res = model_dot(n);
    start = 1'b1; len = (AW+1)'(ln);
    tick();
    start = 1'b0; load_en = 1'b0;
    beats = 0; clears = 0; lat = 0;
    while (!result_valid && lat < 100) begin
      if (mac_clear) clears++;
      if (data_out.valid || weight_out.valid) begin
        if (beats < DEPTH) begin
          check("beat_data", 64'(data_out), 64'({1'b1, ref_d[beats]}));
          check("beat_weight", 64'(weight_out), 64'({1'b1, ref_w[beats]}));
        end
        beats++;
      end
      if (lat == inj) begin
        load_en = 1'b1; load_addr = '0; load_data = 32'h7f00_0000; load_weight = 32'h7f00_0000;
      end else begin
        load_en = 1'b0;
      end
      tick();
      lat++;
    end
    load_en = 1'b0;
    got = result;
    check("latency", 64'(lat), 64'(n + 2));
    check("beat_count", 64'(beats), 64'(n));
    check("clear_count", 64'(clears), 64'(1));
    check("result", 64'(result), 64'(exp_res));
    result_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      if (pulse) begin start = 1'b1; len = (AW+1)'(3); end
      tick();
      start = 1'b0;
      check("hold_valid", 64'(result_valid), 64'(1));
      check("hold_result", 64'(result), 64'(exp_res));
      check("hold_busy", 64'(busy), 64'(1));
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("ack_valid", 64'(result_valid), 64'(0));
    check("ack_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] got;
    vecs[0] = '{len: 1,         hold: 0, exp_beats: 1,     exp_lat: 3};
    vecs[1] = '{len: DEPTH,     hold: 1, exp_beats: DEPTH, exp_lat: DEPTH + 2};
    vecs[2] = '{len: DEPTH + 3, hold: 0, exp_beats: DEPTH, exp_lat: DEPTH + 2};
    vecs[3] = '{len: 0,         hold: 2, exp_beats: 0,     exp_lat: 2};
    vecs[4] = '{len: 5,         hold: 0, exp_beats: 5,     exp_lat: 7};
    vecs[5] = '{len: 31,        hold: 0, exp_beats: DEPTH, exp_lat: DEPTH + 2};

    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0; load_weight = '0;
    start = 1'b0; len = '0; result_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_valid", 64'(result_valid), 64'(0));
    check("rst_clear", 64'(mac_clear), 64'(0));
    check("rst_data", 64'(data_out), 64'(0));
    check("rst_result", 64'(result), 64'(0));

    for (int a = 0; a < DEPTH; a++) load(a, rnd_num(), rnd_num());
    load(0, 32'h3f80_0000, 32'h4040_0000);
    load(1, 32'h4000_0000, 32'h4080_0000);

    run(2, 0, 1'b0, -1, 1'b0, 0, '0, '0, got);
    check("basic_11", 64'(got), 64'(32'h4130_0000));

    // Table of lengths with independently stated beat counts and latencies.
    for (int i = 0; i < 6; i++) begin
      int nb, lt;
      nb = 0; lt = 0;
      start = 1'b1; len = (AW+1)'(vecs[i].len);
      tick();
      start = 1'b0;
      while (!result_valid && lt < 100) begin
        if (data_out.valid) nb++;
        tick();
        lt++;
      end
      check("vec_beats", 64'(nb), 64'(vecs[i].exp_beats));
      check("vec_lat", 64'(lt), 64'(vecs[i].exp_lat));
      check("vec_result", 64'(result), 64'(model_dot(vecs[i].exp_beats)));
      for (int h = 0; h < vecs[i].hold; h++) tick();
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
      check("vec_idle", 64'(busy), 64'(0));
    end

    // len=0 yields zero even after a non-zero product was accumulated.
    run(0, 0, 1'b0, -1, 1'b0, 0, '0, '0, got);
    check("len0_zero", 64'(got), 64'(0));

    // Back-pressure with start pulses while DONE.
    run(2, 4, 1'b1, -1, 1'b0, 0, '0, '0, got);
    check("bp_11", 64'(got), 64'(32'h4130_0000));

    // Reset after the first beat of a len=4 stream.
    start = 1'b1; len = (AW+1)'(4);
    tick();
    start = 1'b0;
    tick();
    check("mid_beat0", 64'(data_out.valid), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_data", 64'(data_out), 64'(0));
    check("mid_rst_weight", 64'(weight_out), 64'(0));
    check("mid_rst_clear", 64'(mac_clear), 64'(0));
    check("mid_rst_result", 64'(result), 64'(0));
    check("mid_rst_valid", 64'(result_valid), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    run(2, 0, 1'b0, -1, 1'b0, 0, '0, '0, got);
    check("mid_rerun_11", 64'(got), 64'(32'h4130_0000));

    // Load attempted during STREAM must not reach the buffer.
    run(4, 0, 1'b0, 1, 1'b0, 0, '0, '0, got);
    run(2, 0, 1'b0, -1, 1'b0, 0, '0, '0, got);
    check("stream_load_ignored", 64'(got), 64'(32'h4130_0000));

    // Load in the same cycle as start is visible to the stream.
    run(1, 0, 1'b0, -1, 1'b1, 0, 32'h40a0_0000, 32'h40c0_0000, got);
    check("same_cycle_load", 64'(got), 64'(32'h41f0_0000));

    // Randomized transactions against the reference model.
    for (int it = 0; it < 25; it++) begin
      for (int j = 0; j < 3; j++) load(int'($urandom_range(0, DEPTH - 1)), rnd_num(), rnd_num());
      run(int'($urandom_range(0, 31)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1,
          1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)), rnd_num(), rnd_num(), got);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
